// File: rtl/mem_stage_access_unit_if.sv
// Bus bundle for the MEM-stage access unit.
// Groups the EX/MEM input word, the data-memory req/ack channel, the
// MEM/WB output word and the sticky error flags.
//   slave  : the access unit itself
//   master : the surrounding pipeline / memory model
// Ports carried:
//   ex_mem_bus[71:0], ex_mem_valid   EX/MEM word and its valid
//   stall_out                        hold upstream stages
//   dmem_req/we/addr/wdata           data-memory request
//   dmem_rdata, dmem_ack             data-memory response
//   mem_wb_bus[69:0], mem_wb_valid   MEM/WB word and its one-cycle valid
//   err_misaligned, err_timeout      sticky error flags
interface mem_stage_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic [71:0]       ex_mem_bus;
    logic              ex_mem_valid;
    logic              stall_out;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;
    logic [69:0]       mem_wb_bus;
    logic              mem_wb_valid;
    logic              err_misaligned;
    logic              err_timeout;

    modport slave (
        input  ex_mem_bus, ex_mem_valid, dmem_rdata, dmem_ack,
        output stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               mem_wb_bus, mem_wb_valid, err_misaligned, err_timeout
    );

    modport master (
        output ex_mem_bus, ex_mem_valid, dmem_rdata, dmem_ack,
        input  stall_out, dmem_req, dmem_we, dmem_addr, dmem_wdata,
               mem_wb_bus, mem_wb_valid, err_misaligned, err_timeout
    );
endinterface

// File: rtl/mem_stage_access_unit.sv
// MEM-stage access unit.
// Unpacks the 72-bit EX/MEM word, performs the load/store on the data memory
// over a req/ack handshake, and emits a 70-bit MEM/WB word with a one-cycle
// valid. Stalls upstream while an access is outstanding. All state changes on
// the falling edge of clk; reset is asynchronous, active-low.
// Ports:
//   clk    pipeline clock (falling-edge active)
//   reset  async active-low reset
//   io     mem_stage_access_unit_if.slave bundle
//          ex_mem_bus: [71]MemRead [70]MemWrite [69]MemToReg [68:64]RD
//                      [63:32]Rd2 [31:0]ALU_result
//          mem_wb_bus: [69]MemToReg [68:64]RD [63:32]ReadData [31:0]ALU_result
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | accepting EX/MEM words; pass-through / misaligned finish here
// ACCESS | dmem_req held, stall_out high, counting cycles toward timeout
// DONE   | access finished; MEM/WB word issued on the edge leaving DONE
module mem_stage_access_unit #(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_stage_access_unit_if.slave  io
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last count value before the abort; the abort edge brings the count to TIMEOUT.
    localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_mem_to_reg;
    logic [4:0]  in_rd;
    logic [31:0] in_rd2;
    logic [31:0] in_alu;
    logic        in_is_mem;
    logic        in_misaligned;

    assign in_mem_read   = io.ex_mem_bus[71];
    assign in_mem_write  = io.ex_mem_bus[70];
    assign in_mem_to_reg = io.ex_mem_bus[69];
    assign in_rd         = io.ex_mem_bus[68:64];
    assign in_rd2        = io.ex_mem_bus[63:32];
    assign in_alu        = io.ex_mem_bus[31:0];
    assign in_is_mem     = in_mem_read | in_mem_write;
    assign in_misaligned = (in_alu[1:0] != 2'b00);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              stall_q, stall_d;
    logic [69:0]       wb_bus_q, wb_bus_d;
    logic              wb_valid_q, wb_valid_d;
    logic              err_mis_q, err_mis_d;
    logic              err_to_q, err_to_d;
    logic              mtr_q, mtr_d;
    logic [4:0]        rd_q, rd_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       rdata_q, rdata_d;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            stall_q    <= 1'b0;
            wb_bus_q   <= 70'h0;
            wb_valid_q <= 1'b0;
            err_mis_q  <= 1'b0;
            err_to_q   <= 1'b0;
            mtr_q      <= 1'b0;
            rd_q       <= 5'd0;
            alu_q      <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            stall_q    <= stall_d;
            wb_bus_q   <= wb_bus_d;
            wb_valid_q <= wb_valid_d;
            err_mis_q  <= err_mis_d;
            err_to_q   <= err_to_d;
            mtr_q      <= mtr_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        stall_d    = stall_q;
        wb_bus_d   = wb_bus_q;
        wb_valid_d = 1'b0;
        err_mis_d  = err_mis_q;
        err_to_d   = err_to_q;
        mtr_d      = mtr_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;

        case (state_q)
            IDLE: begin
                if (io.ex_mem_valid) begin
                    if (!in_is_mem || in_misaligned) begin
                        // ALU op or rejected misaligned access: finish in one edge.
                        wb_bus_d   = {in_mem_to_reg, in_rd, 32'h0, in_alu};
                        wb_valid_d = 1'b1;
                        if (in_is_mem) begin
                            err_mis_d = 1'b1;
                        end
                    end else begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        stall_d = 1'b1;
                        // Read+write together is executed as a store.
                        we_d    = in_mem_write;
                        addr_d  = in_alu[ADDR_W+1:2];
                        wdata_d = in_rd2;
                        cnt_d   = 4'd0;
                        mtr_d   = in_mem_to_reg;
                        rd_d    = in_rd;
                        alu_d   = in_alu;
                    end
                end
            end
            ACCESS: begin
                if (io.dmem_ack) begin
                    req_d   = 1'b0;
                    stall_d = 1'b0;
                    rdata_d = we_q ? 32'h0 : io.dmem_rdata;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d    = 1'b0;
                    stall_d  = 1'b0;
                    err_to_d = 1'b1;
                    rdata_d  = 32'h0;
                    cnt_d    = cnt_q + 4'd1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // Stall already released on entry so upstream advances this
                // cycle; the bus is not sampled here, avoiding a re-issue.
                wb_bus_d   = {mtr_q, rd_q, rdata_q, alu_q};
                wb_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign io.stall_out      = stall_q;
    assign io.dmem_req       = req_q;
    assign io.dmem_we        = we_q;
    assign io.dmem_addr      = addr_q;
    assign io.dmem_wdata     = wdata_q;
    assign io.mem_wb_bus     = wb_bus_q;
    assign io.mem_wb_valid   = wb_valid_q;
    assign io.err_misaligned = err_mis_q;
    assign io.err_timeout    = err_to_q;

endmodule
